// File: rtl/round_sequencer.sv
// Blink memory-game round: plays an LFSR-derived LED pattern, then checks the player's presses against it.
// Optional build macro ROUND_SEQ_TIMEOUT_EN adds a per-press inactivity timeout in the input phase.
module round_sequencer #(
  parameter int BLINK_CYCLES   = 50_000_000,
  parameter int GAP_CYCLES     = 25_000_000,
  parameter int TIMEOUT_CYCLES = 250_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] level,
  input  logic [7:0] seed,
  input  logic [3:0] btn,
  output logic [3:0] led,
  output logic       busy,
  output logic       pass,
  output logic       fail
);

  localparam int MAX_BG  = (BLINK_CYCLES > GAP_CYCLES) ? BLINK_CYCLES : GAP_CYCLES;
  localparam int MAX_CYC = (MAX_BG > TIMEOUT_CYCLES) ? MAX_BG : TIMEOUT_CYCLES;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TW-1:0] BLINK_LAST = TW'(BLINK_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYCLES - 1);
`ifdef ROUND_SEQ_TIMEOUT_EN
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_SHOW_ON, ST_SHOW_OFF, ST_INPUT, ST_PASS, ST_FAIL
  } state_t;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [3:0] one_hot(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

  state_t        state_q, state_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [7:0]    seed_q, seed_d;
  logic [2:0]    last_q, last_d;
  logic [2:0]    idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    led_q, led_d;
  logic          busy_q, busy_d;
  logic          pass_q, pass_d;
  logic          fail_q, fail_d;

  // Next-state, counters and output decode (outputs are registered from the next state)
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    seed_d  = seed_q;
    last_d  = last_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
        else       state_d = ST_IDLE;
      end
      ST_LOAD: begin
        // last_d holds len-1, with level clamped to 1..4
        if (level == 3'd0)       last_d = 3'd2;
        else if (level >= 3'd4)  last_d = 3'd5;
        else                     last_d = level + 3'd1;
        seed_d  = (seed == 8'h00) ? 8'h01 : seed;
        lfsr_d  = (seed == 8'h00) ? 8'h01 : seed;
        idx_d   = 3'd0;
        timer_d = '0;
        state_d = ST_SHOW_ON;
      end
      ST_SHOW_ON: begin
        if (timer_q == BLINK_LAST) begin
          timer_d = '0;
          state_d = ST_SHOW_OFF;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_SHOW_OFF: begin
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          if (idx_q == last_q) begin
            lfsr_d  = seed_q;  // replay the pattern from the saved seed
            idx_d   = 3'd0;
            state_d = ST_INPUT;
          end else begin
            lfsr_d  = lfsr_step(lfsr_q);
            idx_d   = idx_q + 3'd1;
            state_d = ST_SHOW_ON;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_INPUT: begin
        if (btn == 4'b0000) begin
`ifdef ROUND_SEQ_TIMEOUT_EN
          if (timer_q == TO_LAST) state_d = ST_FAIL;
          else                    timer_d = timer_q + 1'b1;
`else
          timer_d = timer_q + 1'b1;
`endif
        end else if (btn == one_hot(lfsr_q[1:0])) begin
          if (idx_q == last_q) begin
            state_d = ST_PASS;
          end else begin
            lfsr_d  = lfsr_step(lfsr_q);
            idx_d   = idx_q + 3'd1;
            timer_d = '0;
          end
        end else begin
          state_d = ST_FAIL;
        end
      end
      ST_PASS: state_d = ST_IDLE;
      ST_FAIL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    led_d  = (state_d == ST_SHOW_ON) ? one_hot(lfsr_d[1:0]) : 4'b0000;
    busy_d = (state_d != ST_IDLE);
    pass_d = (state_d == ST_PASS);
    fail_d = (state_d == ST_FAIL);
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      lfsr_q  <= 8'h01;
      seed_q  <= 8'h01;
      last_q  <= 3'd0;
      idx_q   <= 3'd0;
      timer_q <= '0;
      led_q   <= 4'b0000;
      busy_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      seed_q  <= seed_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  assign led  = led_q;
  assign busy = busy_q;
  assign pass = pass_q;
  assign fail = fail_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Self-checking bench for round_sequencer: table vectors, randomized rounds against a pattern model,
// and directed reset / start-glitch / timeout sequences (timeout behaviour follows ROUND_SEQ_TIMEOUT_EN).
module tb_round_sequencer;

  localparam int B  = 4;
  localparam int G  = 2;
  localparam int TO = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] level;
  logic [7:0] seed;
  logic [3:0] btn;
  logic [3:0] led;
  logic       busy;
  logic       pass;
  logic       fail;

  int n_tests = 0;
  int n_fail  = 0;

  round_sequencer #(
    .BLINK_CYCLES  (B),
    .GAP_CYCLES    (G),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .level(level),
    .seed (seed),
    .btn  (btn),
    .led  (led),
    .busy (busy),
    .pass (pass),
    .fail (fail)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] seed;
    logic [2:0] level;
    int         wrong_at;   // -1: every press correct
    logic [3:0] wrong_btn;
    bit         glitch;     // extra start pulse during the first gap
    logic [3:0] exp_first;
    bit         exp_pass;
  } vec_t;

  // Reference model: the game rules expressed on whole patterns
  function automatic int m_len(input logic [2:0] lv);
    int l;
    l = int'(lv);
    if (l < 1) l = 1;
    if (l > 4) l = 4;
    return l + 2;
  endfunction

  function automatic logic [3:0] m_elem(input logic [7:0] sd, input int k);
    logic [7:0] s;
    s = (sd == 8'h00) ? 8'h01 : sd;
    for (int i = 0; i < k; i++) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    return 4'b0001 << s[1:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_round(input logic [7:0] sd, input logic [2:0] lv, input int wrong_at,
                           input logic [3:0] wrong_btn, input bit glitch, input bit no_press,
                           input logic [3:0] exp_first, input bit exp_pass);
    logic [3:0] pat[6];
    int len;
    int last_p;
    bit bad;
    len = m_len(lv);
    for (int k = 0; k < 6; k++) pat[k] = m_elem(sd, k);
    check("idle_busy", {31'd0, busy}, 32'd0);
    seed = sd; level = lv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("load_busy", {31'd0, busy}, 32'd1);
    check("load_led", {28'd0, led}, 32'd0);
    bad = 1'b0;
    for (int k = 0; k < len; k++) begin
      for (int c = 0; c < B + G; c++) begin
        @(negedge clk);
        if (k == 0 && c == 0) begin
          check("first_led", {28'd0, led}, {28'd0, exp_first});
          seed = 8'($urandom); level = 3'($urandom);
        end
        if (led !== ((c < B) ? pat[k] : 4'b0000) || busy !== 1'b1 || pass || fail) bad = 1'b1;
        btn   = 4'($urandom);
        start = (glitch && k == 0 && c == B) ? 1'b1 : 1'b0;
      end
    end
    check("show_seq", {31'd0, bad}, 32'd0);
    btn = 4'b0000; start = 1'b0;
    @(negedge clk);
    check("input_entry", {27'd0, led, busy}, {27'd0, 4'b0000, 1'b1});
    if (no_press) begin
`ifdef ROUND_SEQ_TIMEOUT_EN
      bad = 1'b0;
      for (int i = 1; i <= TO; i++) begin
        if (fail || pass || !busy) bad = 1'b1;
        @(negedge clk);
      end
      check("timeout_early", {31'd0, bad}, 32'd0);
      check("timeout_fail", {30'd0, fail, pass}, {30'd0, 2'b10});
      @(negedge clk);
      check("timeout_idle", {29'd0, busy, fail, pass}, 32'd0);
`else
      bad = 1'b0;
      repeat (1000) begin
        @(negedge clk);
        if (fail || pass) bad = 1'b1;
      end
      check("no_timeout", {31'd0, bad}, 32'd0);
      check("still_busy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("reset_exit", {29'd0, busy, fail, pass}, 32'd0);
`endif
      return;
    end
    last_p = exp_pass ? len - 1 : wrong_at;
    for (int p = 0; p <= last_p; p++) begin
      repeat ($urandom_range(0, 9)) begin
        btn = 4'b0000;
        @(negedge clk);
        if (pass || fail || !busy) bad = 1'b1;
      end
      btn = (p == wrong_at) ? wrong_btn : pat[p];
      @(negedge clk);
      btn = 4'b0000;
      if (p != last_p && (pass || fail || !busy)) bad = 1'b1;
    end
    check("input_quiet", {31'd0, bad}, 32'd0);
    check("outcome", {30'd0, pass, fail}, exp_pass ? 32'd2 : 32'd1);
    @(negedge clk);
    check("back_idle", {29'd0, busy, pass, fail}, 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'h01, 3'd1, -1, 4'b0000, 1'b1, 4'b0010, 1'b1};
    vecs[1] = '{8'h00, 3'd0, -1, 4'b0000, 1'b0, 4'b0010, 1'b1};
    vecs[2] = '{8'h01, 3'd4,  1, 4'b1000, 1'b0, 4'b0010, 1'b0};
    vecs[3] = '{8'h01, 3'd1,  0, 4'b0110, 1'b0, 4'b0010, 1'b0};
    vecs[4] = '{8'hA5, 3'd7, -1, 4'b0000, 1'b0, 4'b0010, 1'b1};
    vecs[5] = '{8'h3C, 3'd2,  3, 4'b1111, 1'b0, 4'b0001, 1'b0};

    reset = 1'b1; start = 1'b0; level = 3'd1; seed = 8'h01; btn = 4'b0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_state", {25'd0, led, busy, pass, fail}, 32'd0);
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      run_round(vecs[i].seed, vecs[i].level, vecs[i].wrong_at, vecs[i].wrong_btn,
                vecs[i].glitch, 1'b0, vecs[i].exp_first, vecs[i].exp_pass);

    // Reset in the middle of the first LED
    seed = 8'h01; level = 3'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_show_led", {28'd0, led}, 32'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_reset", {25'd0, led, busy, pass, fail}, 32'd0);
    begin
      bit any;
      any = 1'b0;
      repeat (25) begin
        @(negedge clk);
        if (busy || pass || fail || led != 4'b0000) any = 1'b1;
      end
      check("post_reset_quiet", {31'd0, any}, 32'd0);
    end

    run_round(8'h01, 3'd1, -1, 4'b0000, 1'b0, 1'b1, 4'b0010, 1'b0);
    @(negedge clk);

    for (int r = 0; r < 20; r++) begin
      logic [7:0] sd;
      logic [2:0] lv;
      int         wa;
      logic [3:0] wb;
      sd = 8'($urandom);
      lv = 3'($urandom);
      wa = $urandom_range(0, 7);
      if (wa >= m_len(lv)) wa = -1;
      wb = 4'($urandom_range(1, 15));
      if (wa >= 0 && wb == m_elem(sd, wa)) wb = ~wb;
      run_round(sd, lv, wa, wb, 1'($urandom), 1'b0, m_elem(sd, 0), wa < 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
